// File: rtl/kypd_emulator.sv
// kypd_emulator: synthesizable stand-in for the passive 4x4 PmodKYPD matrix.
// A host command (key_code, hold_cycles) closes one switch of the matrix for a
// programmed time, with contact bounce on press and release. The scanner's
// column strobes are reflected onto the row lines combinationally.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   col[3:0]    in       column strobes from the scanner (active-low)
//   row[3:0]    out      row lines back to the scanner (active-low, idle high)
//   key_valid   in       host command valid
//   key_ready   out      emulator idle, command can be accepted
//   key_code    in       hex key to press
//   hold_cycles in       solid-contact time in cycles (0 behaves as 1)
//   busy        out      command in flight (accept .. end of gap)
//   done        out      one-cycle pulse on the last gap cycle
module kypd_emulator #(
  parameter int BOUNCE_PERIOD  = 16,
  parameter int BOUNCE_TOGGLES = 6,
  parameter int GAP_CYCLES     = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [3:0]  key_code,
  input  logic [15:0] hold_cycles,
  output logic        busy,
  output logic        done
);

  localparam int MAXC = (BOUNCE_PERIOD > GAP_CYCLES) ? BOUNCE_PERIOD : GAP_CYCLES;
  localparam int CW   = ($clog2(MAXC + 1) > 16) ? $clog2(MAXC + 1) : 16;
  localparam int TW   = (BOUNCE_TOGGLES > 1) ? $clog2(BOUNCE_TOGGLES) : 1;
  localparam logic [TW-1:0] TLAST = (BOUNCE_TOGGLES > 0) ? TW'(BOUNCE_TOGGLES - 1) : '0;
  localparam logic [CW-1:0] P_LD  = CW'(BOUNCE_PERIOD - 1);
  localparam logic [CW-1:0] G_LD  = CW'(GAP_CYCLES - 1);
  localparam logic BOUNCE_EN = (BOUNCE_TOGGLES != 0);

  typedef enum logic [2:0] {S_IDLE, S_BIN, S_HOLD, S_BOUT, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [TW-1:0] r_tog, w_tog_nxt;
  logic [15:0]   r_hold_ld;
  logic [1:0]    r_row, r_col;
  logic          r_closed, w_closed_nxt;
  logic          w_accept, w_cnt_end, w_tog_end;
  logic [15:0]   w_hold_ld;
  logic [1:0]    w_kr, w_kc;

  assign key_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = key_valid && key_ready;
  assign w_cnt_end = (r_cnt == '0);
  assign w_tog_end = (r_tog == TLAST);
  assign done      = (r_state == S_GAP) && w_cnt_end;

  // Counters run down to zero, so the load value is length-1; hold of 0 loads
  // the same value as hold of 1, and 0xFFFF gives 65535 cycles without wrap.
  assign w_hold_ld = (hold_cycles == 16'd0) ? 16'd0 : hold_cycles - 16'd1;

  // Key map, row-major: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
  always_comb begin
    w_kr = 2'd0;
    w_kc = 2'd0;
    case (key_code)
      4'h1: begin w_kr = 2'd0; w_kc = 2'd0; end
      4'h2: begin w_kr = 2'd0; w_kc = 2'd1; end
      4'h3: begin w_kr = 2'd0; w_kc = 2'd2; end
      4'hA: begin w_kr = 2'd0; w_kc = 2'd3; end
      4'h4: begin w_kr = 2'd1; w_kc = 2'd0; end
      4'h5: begin w_kr = 2'd1; w_kc = 2'd1; end
      4'h6: begin w_kr = 2'd1; w_kc = 2'd2; end
      4'hB: begin w_kr = 2'd1; w_kc = 2'd3; end
      4'h7: begin w_kr = 2'd2; w_kc = 2'd0; end
      4'h8: begin w_kr = 2'd2; w_kc = 2'd1; end
      4'h9: begin w_kr = 2'd2; w_kc = 2'd2; end
      4'hC: begin w_kr = 2'd2; w_kc = 2'd3; end
      4'h0: begin w_kr = 2'd3; w_kc = 2'd0; end
      4'hF: begin w_kr = 2'd3; w_kc = 2'd1; end
      4'hE: begin w_kr = 2'd3; w_kc = 2'd2; end
      default: begin w_kr = 2'd3; w_kc = 2'd3; end  // 4'hD
    endcase
  end

  // Each bounce burst is BOUNCE_TOGGLES phases of BOUNCE_PERIOD cycles; the
  // toggle out of the last phase is the entry into the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tog_nxt   = r_tog;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_tog_nxt = '0;
        if (BOUNCE_EN) begin
          w_state_nxt = S_BIN;
          w_cnt_nxt   = P_LD;
        end else begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = CW'(w_hold_ld);
        end
      end
      S_BIN: begin
        if (!w_cnt_end) w_cnt_nxt = r_cnt - CW'(1);
        else if (w_tog_end) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = CW'(r_hold_ld);
        end else begin
          w_tog_nxt = r_tog + TW'(1);
          w_cnt_nxt = P_LD;
        end
      end
      S_HOLD: begin
        if (!w_cnt_end) w_cnt_nxt = r_cnt - CW'(1);
        else if (BOUNCE_EN) begin
          w_state_nxt = S_BOUT;
          w_cnt_nxt   = P_LD;
          w_tog_nxt   = '0;
        end else begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = G_LD;
        end
      end
      S_BOUT: begin
        if (!w_cnt_end) w_cnt_nxt = r_cnt - CW'(1);
        else if (w_tog_end) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = G_LD;
        end else begin
          w_tog_nxt = r_tog + TW'(1);
          w_cnt_nxt = P_LD;
        end
      end
      S_GAP: begin
        if (w_cnt_end) w_state_nxt = S_IDLE;
        else           w_cnt_nxt   = r_cnt - CW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Press bursts start closed, release bursts start open; even phases keep
  // the starting level.
  always_comb begin
    w_closed_nxt = 1'b0;
    case (w_state_nxt)
      S_BIN:   w_closed_nxt = ~w_tog_nxt[0];
      S_HOLD:  w_closed_nxt = 1'b1;
      S_BOUT:  w_closed_nxt = w_tog_nxt[0];
      default: w_closed_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tog     <= '0;
      r_closed  <= 1'b0;
      r_hold_ld <= 16'd0;
      r_row     <= 2'd0;
      r_col     <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tog    <= w_tog_nxt;
      r_closed <= w_closed_nxt;
      if (w_accept) begin
        r_hold_ld <= w_hold_ld;
        r_row     <= w_kr;
        r_col     <= w_kc;
      end
    end
  end

  // Passive switch: the row follows the column strobe with no clock latency.
  always_comb begin
    row = 4'hF;
    if (r_closed && !col[r_col]) row[r_row] = 1'b0;
  end

endmodule
